// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multicycle RV32I-subset datapath that shares one
// memory port for instruction fetch and data access.
//
// Per-instruction sequence:
//   FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH
// Illegal opcodes and memory timeouts park the controller in HALT. Only reset
// leaves HALT.
//
// Parameters
//   timeout_cycles : consecutive mem_ready-low cycles tolerated in FETCH or
//                    MEMORY before the access is abandoned with bus_error.
//
// Optional feature
//   CTRL_PERF_COUNTERS_EN : when defined, adds cycle_count (counts non-HALT
//                           cycles) and instret_count (counts pc_write pulses).
//
// Ports
//   clk, reset                 : rising-edge clock, asynchronous active-high reset
//   opcode, func_3_bits        : instruction-register fields
//   alu_zero                   : ALU zero flag (branch compare result)
//   mem_ready                  : memory access done / read data valid this cycle
//   mem_read, mem_write        : memory strobes
//   mem_address_source         : 0 = PC, 1 = ALU result
//   ir_write                   : load instruction register
//   pc_write, pc_source        : update PC; 0 = PC+4, 1 = branch target
//   register_write             : register file write enable
//   memory_to_register         : writeback data from memory (loads)
//   alu_source                 : 0 = rs2, 1 = immediate
//   alu_option                 : ALU operation select
//   AuipcLui                   : ALU operand A: 0 = PC, 1 = zero, 2 = rs1
//   state                      : current FSM state encoding
//   illegal_instruction        : sticky, set on an illegal opcode
//   bus_error                  : sticky, set on a memory timeout
//   cycle_count, instret_count : performance counters (optional)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned timeout_cycles = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func_3_bits,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_address_source,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_source,
    output logic        register_write,
    output logic        memory_to_register,
    output logic        alu_source,
    output logic [3:0]  alu_option,
    output logic [1:0]  AuipcLui,
    output logic [2:0]  state,
    output logic        illegal_instruction,
    output logic        bus_error
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OpR,
        OpImm,
        OpLoad,
        OpStore,
        OpBranch,
        OpLui,
        OpAuipc,
        OpIllegal
    } op_e;

    localparam int unsigned WaitW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
    // Counter value seen on the last tolerated low cycle.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(timeout_cycles - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [3:0]       alu_option_q, alu_option_d;
    logic             alu_source_q, alu_source_d;
    logic [1:0]       auipc_lui_q, auipc_lui_d;

    op_e              op_dec;
    logic [3:0]       alu_option_dec;
    logic             alu_source_dec;
    logic [1:0]       auipc_lui_dec;
    logic             wait_expired;
    logic             branch_taken;

    // Opcode classification.
    always_comb begin
        case (opcode)
            7'b0110011: op_dec = OpR;
            7'b0010011: op_dec = OpImm;
            7'b0000011: op_dec = OpLoad;
            7'b0100011: op_dec = OpStore;
            7'b1100011: op_dec = OpBranch;
            7'b0110111: op_dec = OpLui;
            7'b0010111: op_dec = OpAuipc;
            default:    op_dec = OpIllegal;
        endcase
    end

    // ALU controls for the decoded class; captured at the end of DECODE so
    // they stay stable through EXECUTE, MEMORY and WRITEBACK.
    always_comb begin
        alu_option_dec = 4'b0000;
        alu_source_dec = 1'b1;
        auipc_lui_dec  = 2'd2;
        case (op_dec)
            OpR: begin
                alu_option_dec = 4'b0010;
                alu_source_dec = 1'b0;
            end
            OpImm:    alu_option_dec = 4'b0011;
            OpBranch: begin
                alu_option_dec = 4'b0001;
                alu_source_dec = 1'b0;
            end
            OpLui:    auipc_lui_dec = 2'd1;
            OpAuipc:  auipc_lui_dec = 2'd0;
            default:  ;
        endcase
    end

    assign wait_expired = !mem_ready && (wait_q == WaitLast);

    // beq taken on zero, bne taken on non-zero; other funct3 never taken.
    assign branch_taken = ((func_3_bits == 3'b000) && alu_zero) ||
                          ((func_3_bits == 3'b001) && !alu_zero);

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        // Counter is zero whenever the FSM is not waiting, so it is clear on
        // every entry to FETCH or MEMORY.
        wait_d       = '0;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        alu_option_d = alu_option_q;
        alu_source_d = alu_source_q;
        auipc_lui_d  = auipc_lui_q;

        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                op_d = op_dec;
                if (op_dec == OpIllegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d      = StExecute;
                    alu_option_d = alu_option_dec;
                    alu_source_d = alu_source_dec;
                    auipc_lui_d  = auipc_lui_dec;
                end
            end
            StExecute: begin
                case (op_q)
                    OpLoad, OpStore: state_d = StMemory;
                    OpBranch:        state_d = StFetch;
                    default:         state_d = StWriteback;
                endcase
            end
            StMemory: begin
                if (mem_ready) begin
                    state_d = (op_q == OpLoad) ? StWriteback : StFetch;
                end else if (wait_expired) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            op_q         <= OpR;
            wait_q       <= '0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            alu_option_q <= 4'b0000;
            alu_source_q <= 1'b0;
            auipc_lui_q  <= 2'd2;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wait_q       <= wait_d;
            illegal_q    <= illegal_d;
            bus_err_q    <= bus_err_d;
            alu_option_q <= alu_option_d;
            alu_source_q <= alu_source_d;
            auipc_lui_q  <= auipc_lui_d;
        end
    end

    // Output decode. Reset masks everything combinationally so strobes drop
    // in the same cycle reset rises, even mid-access.
    always_comb begin
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_address_source = 1'b0;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        pc_source          = 1'b0;
        register_write     = 1'b0;
        memory_to_register = 1'b0;
        alu_source         = 1'b0;
        alu_option         = 4'b0000;
        AuipcLui           = 2'd2;

        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                StExecute: begin
                    alu_option = alu_option_q;
                    alu_source = alu_source_q;
                    AuipcLui   = auipc_lui_q;
                    if (op_q == OpBranch) begin
                        pc_write  = 1'b1;
                        pc_source = branch_taken;
                    end
                end
                StMemory: begin
                    alu_option         = alu_option_q;
                    alu_source         = alu_source_q;
                    AuipcLui           = auipc_lui_q;
                    mem_address_source = 1'b1;
                    mem_read           = (op_q == OpLoad);
                    mem_write          = (op_q == OpStore);
                    pc_write           = (op_q == OpStore) && mem_ready;
                end
                StWriteback: begin
                    alu_option         = alu_option_q;
                    alu_source         = alu_source_q;
                    AuipcLui           = auipc_lui_q;
                    register_write     = 1'b1;
                    memory_to_register = (op_q == OpLoad);
                    pc_write           = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state               = state_q;
    assign illegal_instruction = illegal_q;
    assign bus_error           = bus_err_q;

`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instret_count_q, instret_count_d;

    always_comb begin
        cycle_count_d   = cycle_count_q + {31'd0, (state_q != StHalt)};
        instret_count_d = instret_count_q + {31'd0, pc_write};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. A per-instruction trace model builds
// the expected output vector for each cycle into a queue; a driver replays the
// queued mem_ready values and one compare process checks every cycle.
module tb_multicycle_controller;

    localparam int unsigned T = 16;
    localparam logic [6:0] OpRv  = 7'b0110011;
    localparam logic [6:0] OpIv  = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpLui = 7'b0110111;
    localparam logic [6:0] OpAui = 7'b0010111;
    localparam logic [6:0] OpJal = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] func_3_bits;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_read, mem_write, mem_address_source, ir_write, pc_write, pc_source;
    logic       register_write, memory_to_register, alu_source;
    logic [3:0] alu_option;
    logic [1:0] AuipcLui;
    logic [2:0] state;
    logic       illegal_instruction, bus_error;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instret_count;
    int unsigned exp_cc, exp_ir;
`endif

    multicycle_controller #(.timeout_cycles(T)) dut (
        .clk                (clk),
        .reset              (reset),
        .opcode             (opcode),
        .func_3_bits        (func_3_bits),
        .alu_zero           (alu_zero),
        .mem_ready          (mem_ready),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address_source (mem_address_source),
        .ir_write           (ir_write),
        .pc_write           (pc_write),
        .pc_source          (pc_source),
        .register_write     (register_write),
        .memory_to_register (memory_to_register),
        .alu_source         (alu_source),
        .alu_option         (alu_option),
        .AuipcLui           (AuipcLui),
        .state              (state),
        .illegal_instruction(illegal_instruction),
        .bus_error          (bus_error)
`ifdef CTRL_PERF_COUNTERS_EN
        ,
        .cycle_count        (cycle_count),
        .instret_count      (instret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr_in;
        logic [2:0] st;
        logic       mem_read, mem_write, mas, ir_write, pc_write, pc_source;
        logic       reg_write, m2r, alu_src;
        logic [3:0] alu_op;
        logic [1:0] auipclui;
        logic       ill, berr;
    } cyc_t;

    cyc_t cur, act;
    cyc_t q[$];
    logic cur_valid = 1'b0;
    logic m_ill, m_berr;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   st_cnt[8];
    int   npw, nrw;
    logic exe_pcw, exe_pcsrc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 8; i++) st_cnt[i] = 0;
        npw = 0;
        nrw = 0;
        exe_pcw = 1'b0;
        exe_pcsrc = 1'b0;
    endtask

    // ---------------- trace model ----------------
    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.mr_in = 1'b1;
        c.st = st;
        c.auipclui = 2'd2;
        c.ill = m_ill;
        c.berr = m_berr;
        return c;
    endfunction

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) q.push_back(blank(3'd5));
    endtask

    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic az,
                               input int fw, input int mw);
        cyc_t c;
        logic [3:0] a_op;
        logic       a_src;
        logic [1:0] a_al;
        logic       is_ld, is_st, is_br, legal;
        is_ld = (op == OpLd);
        is_st = (op == OpSt);
        is_br = (op == OpBr);
        legal = (op == OpRv) || (op == OpIv) || is_ld || is_st || is_br ||
                (op == OpLui) || (op == OpAui);
        a_op  = (op == OpRv) ? 4'b0010 : (op == OpIv) ? 4'b0011 : is_br ? 4'b0001 : 4'b0000;
        a_src = !((op == OpRv) || is_br);
        a_al  = (op == OpAui) ? 2'd0 : (op == OpLui) ? 2'd1 : 2'd2;

        // fetch: wait cycles then the completing cycle
        for (int i = 0; i < fw && i < int'(T); i++) begin
            c = blank(3'd0);
            c.mr_in = 1'b0;
            c.mem_read = 1'b1;
            q.push_back(c);
        end
        if (fw >= int'(T)) begin
            m_berr = 1'b1;
            push_halt(3);
            return;
        end
        c = blank(3'd0);
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        q.push_back(c);
        q.push_back(blank(3'd1));
        if (!legal) begin
            m_ill = 1'b1;
            push_halt(3);
            return;
        end
        // execute
        c = blank(3'd2);
        c.alu_op = a_op;
        c.alu_src = a_src;
        c.auipclui = a_al;
        if (is_br) begin
            c.pc_write = 1'b1;
            c.pc_source = ((f3 == 3'b000) && az) || ((f3 == 3'b001) && !az);
            q.push_back(c);
            return;
        end
        q.push_back(c);
        // memory
        if (is_ld || is_st) begin
            for (int i = 0; i <= mw && i <= int'(T); i++) begin
                if (i == int'(T)) begin
                    m_berr = 1'b1;
                    push_halt(3);
                    return;
                end
                c = blank(3'd3);
                c.alu_op = a_op;
                c.alu_src = a_src;
                c.auipclui = a_al;
                c.mas = 1'b1;
                c.mem_read = is_ld;
                c.mem_write = is_st;
                c.mr_in = (i == mw);
                c.pc_write = is_st && (i == mw);
                q.push_back(c);
            end
            if (is_st) return;
        end
        // writeback
        c = blank(3'd4);
        c.alu_op = a_op;
        c.alu_src = a_src;
        c.auipclui = a_al;
        c.reg_write = 1'b1;
        c.m2r = is_ld;
        c.pc_write = 1'b1;
        q.push_back(c);
    endtask

    // ---------------- driver ----------------
    task automatic run_q(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            cur = q.pop_front();
            mem_ready = cur.mr_in;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic az,
                             input int fw, input int mw);
        opcode = op;
        func_3_bits = f3;
        alu_zero = az;
        model_instr(op, f3, az, fw, mw);
        run_q(q.size());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_ir_write", 32'(ir_write), 32'd0);
        check("rst_alu_option", 32'(alu_option), 32'd0);
        check("rst_auipclui", 32'(AuipcLui), 32'd2);
        check("rst_flags", {30'd0, illegal_instruction, bus_error}, 32'd0);
`ifdef CTRL_PERF_COUNTERS_EN
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_instret_count", instret_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ill = 1'b0;
        m_berr = 1'b0;
        q.delete();
`ifdef CTRL_PERF_COUNTERS_EN
        exp_cc = 0;
        exp_ir = 0;
`endif
        #1;
        check("post_rst_mem_read", 32'(mem_read), 32'd1);
        clr_stats();
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cur_valid) begin
                act = '0;
                act.mr_in = cur.mr_in;
                act.st = state;
                act.mem_read = mem_read;
                act.mem_write = mem_write;
                act.mas = mem_address_source;
                act.ir_write = ir_write;
                act.pc_write = pc_write;
                act.pc_source = pc_source;
                act.reg_write = register_write;
                act.m2r = memory_to_register;
                act.alu_src = alu_source;
                act.alu_op = alu_option;
                act.auipclui = AuipcLui;
                act.ill = illegal_instruction;
                act.berr = bus_error;
                n_tests++;
                if (act !== cur) begin
                    n_fail++;
                    $display("FAIL trace t=%0t: got %h expected %h (st got %0d exp %0d)",
                             $time, act, cur, act.st, cur.st);
                end
                st_cnt[state]++;
                if (pc_write) npw++;
                if (register_write) nrw++;
                if (state == 3'd2) begin
                    exe_pcw = pc_write;
                    exe_pcsrc = pc_source;
                end
`ifdef CTRL_PERF_COUNTERS_EN
                check("cycle_count", cycle_count, exp_cc);
                check("instret_count", instret_count, exp_ir);
                if (cur.st != 3'd5) exp_cc++;
                if (cur.pc_write) exp_ir++;
`endif
            end
        end
    end

    // ---------------- directed tests ----------------
    logic [31:0] add_word;

    initial begin
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = '0;
        func_3_bits = '0;
        alu_zero = 1'b0;
        m_ill = 1'b0;
        m_berr = 1'b0;
        clr_stats();
        #2;
        do_reset();

        // add x1,x2,x3
        add_word = 32'h003100B3;
        run_instr(add_word[6:0], add_word[14:12], 1'b0, 0, 0);
        check("add_cycles", 32'(st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[4]), 32'd4);
        check("add_wb_cycles", 32'(st_cnt[4]), 32'd1);
        check("add_pc_writes", 32'(npw), 32'd1);
        check("add_reg_writes", 32'(nrw), 32'd1);

        run_instr(OpIv, 3'b000, 1'b0, 2, 0);
        run_instr(OpLui, 3'b000, 1'b0, 0, 0);
        run_instr(OpAui, 3'b000, 1'b0, 1, 0);

        // lw with three not-ready cycles in MEMORY
        clr_stats();
        run_instr(OpLd, 3'b010, 1'b0, 0, 3);
        check("lw_mem_cycles", 32'(st_cnt[3]), 32'd4);
        check("lw_reg_writes", 32'(nrw), 32'd1);

        clr_stats();
        run_instr(OpSt, 3'b010, 1'b0, 0, 0);
        check("sw_cycles", 32'(st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[3]), 32'd4);
        run_instr(OpSt, 3'b010, 1'b0, 1, 2);

        // branches
        clr_stats();
        run_instr(OpBr, 3'b000, 1'b1, 0, 0);
        check("beq_taken_pcsrc", {30'd0, exe_pcw, exe_pcsrc}, 32'd3);
        check("beq_cycles", 32'(st_cnt[0] + st_cnt[1] + st_cnt[2]), 32'd3);
        run_instr(OpBr, 3'b000, 1'b0, 0, 0);
        check("beq_not_taken_pcsrc", {30'd0, exe_pcw, exe_pcsrc}, 32'd2);
        run_instr(OpBr, 3'b001, 1'b0, 0, 0);
        check("bne_taken_pcsrc", 32'(exe_pcsrc), 32'd1);
        run_instr(OpBr, 3'b100, 1'b1, 0, 0);
        check("blt_never_taken", 32'(exe_pcsrc), 32'd0);

        // ready on the last tolerated fetch cycle completes the access
        clr_stats();
        run_instr(OpRv, 3'b000, 1'b0, int'(T) - 1, 0);
        check("fetch_edge_no_berr", 32'(bus_error), 32'd0);
        check("fetch_edge_decode", 32'(st_cnt[1]), 32'd1);
        check("fetch_edge_wait", 32'(st_cnt[0]), T);

        // fetch timeout
        run_instr(OpRv, 3'b000, 1'b0, int'(T), 0);
        check("fetch_to_state", 32'(state), 32'd5);
        check("fetch_to_berr", 32'(bus_error), 32'd1);
        do_reset();

        // memory timeout on a load
        run_instr(OpLd, 3'b010, 1'b0, 0, int'(T));
        check("mem_to_berr", {30'd0, illegal_instruction, bus_error}, 32'd1);
        do_reset();

        // illegal opcode (jal)
        run_instr(OpJal, 3'b000, 1'b0, 0, 0);
        check("illegal_state", 32'(state), 32'd5);
        check("illegal_flags", {30'd0, illegal_instruction, bus_error}, 32'd2);
        do_reset();

        // reset mid-store
        run_instr(OpIv, 3'b000, 1'b0, 0, 0);
        opcode = OpSt;
        model_instr(OpSt, 3'b010, 1'b0, 0, 5);
        run_q(4);
        #1;
        check("mid_store_mem_write", {29'd0, state, mem_write}, {29'd3, 1'b1});
        reset = 1'b1;
        #1;
        check("mid_store_rst_mem_write", 32'(mem_write), 32'd0);
        check("mid_store_rst_state", 32'(state), 32'd0);
        do_reset();
        run_instr(OpRv, 3'b000, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter timeout_cycles, default 16, max consecutive mem_ready-low cycles tolerated in a memory wait before bus error.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports opcode input 7, func_3_bits input 3, alu_zero input 1: instruction-register fields and ALU zero flag.
REQ-005 SHALL have port mem_ready  input  1  shared memory access complete, read data valid this cycle.
REQ-006 SHALL have ports mem_read, mem_write, mem_address_source (0=PC, 1=ALU result)  output  1 each.
REQ-007 SHALL have ports ir_write, pc_write, pc_source (0=PC+4, 1=branch target)  output  1 each.
REQ-008 SHALL have ports register_write, memory_to_register, alu_source  output  1 each.
REQ-009 SHALL have ports alu_option  output  4 and AuipcLui  output  2 (0=PC, 1=zero, 2=rs1).
REQ-010 SHALL have ports state output 3, illegal_instruction output 1, bus_error output 1 (sticky status).

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; all unlisted strobes 0 in every state.
REQ-012 FETCH: mem_read=1, mem_address_source=0; on mem_ready=1 assert ir_write same cycle (Mealy), go DECODE; else stay.
REQ-013 DECODE: one cycle; legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111 -> EXECUTE; any other -> HALT, set illegal_instruction.
REQ-014 EXECUTE: alu_option R=0010, I-ALU=0011, load/store/LUI/AUIPC=0000, branch=0001; alu_source=1 except R and branch; AuipcLui AUIPC=0, LUI=1, else 2; outputs held through MEMORY/WRITEBACK.
REQ-015 EXECUTE next: load/store -> MEMORY; branch -> FETCH with pc_write=1; others -> WRITEBACK.
REQ-016 Branch pc_source=1 iff (func_3_bits=000 and alu_zero) or (func_3_bits=001 and not alu_zero); other func3 never taken.
REQ-017 MEMORY: mem_address_source=1; load mem_read=1, store mem_write=1; on mem_ready load -> WRITEBACK, store asserts pc_write=1 (pc_source=0) and -> FETCH.
REQ-018 WRITEBACK: register_write=1, memory_to_register=1 only for load, pc_write=1, pc_source=0, -> FETCH.
REQ-019 Cycle counts with mem_ready tied 1: R/I/LUI/AUIPC 4, load 5, store 4, branch 3.
REQ-020 Wait counter clears on entering FETCH/MEMORY, increments each mem_ready-low cycle; after timeout_cycles consecutive low cycles -> HALT, set bus_error.
REQ-021 mem_ready=1 in the cycle the timeout would expire SHALL complete the access, no bus_error.
REQ-022 HALT: all strobes 0, flags held, exit only via reset.
REQ-023 pc_write and ir_write SHALL never assert in the same cycle; at most one of mem_read/mem_write per cycle.

Reset
REQ-024 reset=1 SHALL immediately force state=FETCH, all strobes 0, alu_option=0, AuipcLui=2, counters and flags 0, regardless of state or pending access.
REQ-025 After reset release, first rising edge SHALL begin FETCH with mem_read=1.

Configuration
REQ-026 With CTRL_PERF_COUNTERS_EN defined, SHALL add outputs cycle_count (32, +1 every non-HALT cycle) and instret_count (32, +1 per pc_write), wrap at 2^32, reset to 0.
REQ-027 Without CTRL_PERF_COUNTERS_EN, ports and counter logic SHALL be absent; other behaviour identical.

Verification
REQ-028 add x1,x2,x3 (0x003100B3), mem_ready=1 -> states 0,1,2,4,0; register_write=1 only in cycle 4; pc_write=1 once.
REQ-029 lw (opcode 0000011), mem_ready low 3 cycles in MEMORY -> stays state 3 for 4 cycles, then WRITEBACK with memory_to_register=1.
REQ-030 beq, alu_zero=1 -> EXECUTE pc_write=1, pc_source=1; alu_zero=0 -> pc_source=0; next state FETCH.
REQ-031 opcode 1101111 -> DECODE then HALT, illegal_instruction=1, no strobes until reset.
REQ-032 mem_ready held 0 in FETCH, timeout_cycles=16 -> HALT after 16 cycles, bus_error=1; mem_ready=1 on 16th cycle -> DECODE, no bus_error.
REQ-033 reset pulsed mid-MEMORY store -> mem_write drops same cycle, state=0; with CTRL_PERF_COUNTERS_EN, counters read 0.
